// File: rtl/usb_reset_pkg.sv
// Shared line-state and FSM encodings for the USB bus-reset generator.
package usb_reset_pkg;

    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_SE1 = 2'b11;

    typedef enum logic [2:0] {
        ST_POR       = 3'd0,
        ST_IDLE      = 3'd1,
        ST_SE0_CNT   = 3'd2,
        ST_BUS_RESET = 3'd3,
        ST_HOLD      = 3'd4
    } state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/usb_line_sync.sv
// Multi-stage synchroniser for the {dp,dn} pair; resets to J so no false SE0 appears.
module usb_line_sync
    import usb_reset_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_line,
    output logic [1:0] o_line
);

    logic [SYNC_STAGES-1:0][1:0] r_stage;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stage <= {SYNC_STAGES{LS_J}};
        end else begin
            r_stage <= {r_stage[SYNC_STAGES-2:0], i_line};
        end
    end

    assign o_line = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/usb_bus_reset_gen.sv
// Core reset generator: power-on hold, then USB bus-reset (long SE0) detection with release hold.
module usb_bus_reset_gen
    import usb_reset_pkg::*;
#(
    parameter int unsigned POR_CYCLES  = 4800,
    parameter int unsigned SE0_CYCLES  = 120,
    parameter int unsigned HOLD_CYCLES = 48,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk_48mhz,
    input  logic       reset_n,
    input  logic       usb_p_rx,
    input  logic       usb_n_rx,
    input  logic       usb_tx_en,
    output logic       bootloader_reset,
    output logic       bus_reset_pulse,
    output logic [1:0] line_state,
    output logic       por_done
);

    localparam int unsigned CNT_MAX = max3(POR_CYCLES, SE0_CYCLES, HOLD_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] SE0_LAST  = CNT_W'(SE0_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_e           r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d, w_cnt_inc;
    logic             r_boot_rst, w_boot_rst_d;
    logic             r_pulse, w_pulse_d;
    logic             r_por_done, w_por_done_d;
    logic [1:0]       w_line;
    logic             w_se0;

    usb_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .i_clk   (clk_48mhz),
        .i_rst_n (reset_n),
        .i_line  ({usb_p_rx, usb_n_rx}),
        .o_line  (w_line)
    );

    // tx_en shares this clock domain, so it masks SE0 without synchronisation
    assign w_se0     = (w_line == LS_SE0) && !usb_tx_en;
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_boot_rst_d = r_boot_rst;
        w_pulse_d    = 1'b0;
        w_por_done_d = r_por_done;
        case (r_state)
            ST_POR: begin
                w_cnt_d      = w_cnt_inc;
                w_boot_rst_d = 1'b1;
                if (r_cnt == POR_LAST) begin
                    w_state_d    = ST_IDLE;
                    w_cnt_d      = '0;
                    w_boot_rst_d = 1'b0;
                    w_por_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                w_boot_rst_d = 1'b0;
                if (w_se0) begin
                    w_state_d = ST_SE0_CNT;
                    w_cnt_d   = CNT_W'(1);
                end
            end
            ST_SE0_CNT: begin
                w_boot_rst_d = 1'b0;
                if (!w_se0) begin
                    w_state_d = ST_IDLE;
                    w_cnt_d   = '0;
                end else if (r_cnt == SE0_LAST) begin
                    w_state_d    = ST_BUS_RESET;
                    w_cnt_d      = '0;
                    w_pulse_d    = 1'b1;
                    w_boot_rst_d = 1'b1;
                end else begin
                    w_cnt_d = w_cnt_inc;
                end
            end
            ST_BUS_RESET: begin
                w_boot_rst_d = 1'b1;
                if (!w_se0) begin
                    w_state_d = ST_HOLD;
                    w_cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                w_boot_rst_d = 1'b1;
                // Returning SE0 extends the same bus reset; no second strobe.
                if (w_se0) begin
                    w_state_d = ST_BUS_RESET;
                    w_cnt_d   = '0;
                end else if (r_cnt == HOLD_LAST) begin
                    w_state_d    = ST_IDLE;
                    w_cnt_d      = '0;
                    w_boot_rst_d = 1'b0;
                end else begin
                    w_cnt_d = w_cnt_inc;
                end
            end
            default: begin
                w_state_d    = ST_POR;
                w_cnt_d      = '0;
                w_boot_rst_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_POR;
            r_cnt      <= '0;
            r_boot_rst <= 1'b1;
            r_pulse    <= 1'b0;
            r_por_done <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_boot_rst <= w_boot_rst_d;
            r_pulse    <= w_pulse_d;
            r_por_done <= w_por_done_d;
        end
    end

    assign bootloader_reset = r_boot_rst;
    assign bus_reset_pulse  = r_pulse;
    assign line_state       = w_line;
    assign por_done         = r_por_done;

endmodule

// File: tb/tb_usb_bus_reset_gen.sv
// Directed plus random checks of usb_bus_reset_gen against a cycle-count reference model.
module tb_usb_bus_reset_gen;

    localparam int POR  = 16;
    localparam int SE0N = 8;
    localparam int HOLD = 4;
    localparam int SYNC = 2;

    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;
    localparam logic [1:0] SE1 = 2'b11;

    logic       clk_48mhz = 1'b0;
    logic       reset_n;
    logic       usb_p_rx, usb_n_rx, usb_tx_en;
    logic       bootloader_reset, bus_reset_pulse, por_done;
    logic [1:0] line_state;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pulses   = 0;
    int pulse_cyc = -1;
    int boot_hi  = 0;

    logic [1:0] m_pipe [SYNC];
    int         m_por_left, m_run, m_gap;
    bit         m_active;
    logic       m_boot, m_pulse, m_done;

    usb_bus_reset_gen #(
        .POR_CYCLES  (POR),
        .SE0_CYCLES  (SE0N),
        .HOLD_CYCLES (HOLD),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk_48mhz        (clk_48mhz),
        .reset_n          (reset_n),
        .usb_p_rx         (usb_p_rx),
        .usb_n_rx         (usb_n_rx),
        .usb_tx_en        (usb_tx_en),
        .bootloader_reset (bootloader_reset),
        .bus_reset_pulse  (bus_reset_pulse),
        .line_state       (line_state),
        .por_done         (por_done)
    );

    always #5 clk_48mhz = ~clk_48mhz;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SYNC; i++) m_pipe[i] = J;
        m_por_left = POR;
        m_run      = 0;
        m_gap      = 0;
        m_active   = 1'b0;
        m_boot     = 1'b1;
        m_pulse    = 1'b0;
        m_done     = 1'b0;
    endtask

    // One clock edge of the reference: SE0 is judged on the delayed line seen before the edge.
    task automatic model_edge();
        bit se0;
        se0 = (m_pipe[SYNC-1] == SE0) && !usb_tx_en;
        m_pulse = 1'b0;
        if (m_por_left > 0) begin
            m_por_left--;
            if (m_por_left == 0) begin
                m_boot = 1'b0;
                m_done = 1'b1;
            end
        end else if (!m_active) begin
            if (se0) begin
                m_run++;
                if (m_run == SE0N) begin
                    m_active = 1'b1;
                    m_pulse  = 1'b1;
                    m_boot   = 1'b1;
                    m_gap    = 0;
                    m_run    = 0;
                end
            end else begin
                m_run = 0;
            end
        end else if (se0) begin
            m_gap = 0;
        end else begin
            // One edge to notice SE0 ended, then HOLD cycles of hold time.
            m_gap++;
            if (m_gap == HOLD + 1) begin
                m_active = 1'b0;
                m_boot   = 1'b0;
            end
        end
        for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0] = {usb_p_rx, usb_n_rx};
    endtask

    task automatic check_all(input string where);
        check({where, ".boot"},  16'(bootloader_reset), 16'(m_boot));
        check({where, ".pulse"}, 16'(bus_reset_pulse),  16'(m_pulse));
        check({where, ".line"},  16'(line_state),       16'(m_pipe[SYNC-1]));
        check({where, ".done"},  16'(por_done),         16'(m_done));
    endtask

    task automatic tick();
        @(posedge clk_48mhz);
        model_edge();
        cyc++;
        #1;
        check_all("cycle");
        if (bus_reset_pulse === 1'b1) begin
            pulses++;
            pulse_cyc = cyc;
        end
        if (bootloader_reset === 1'b1) boot_hi++;
    endtask

    task automatic drive(input logic [1:0] ls, input logic tx, input int n);
        usb_p_rx  = ls[1];
        usb_n_rx  = ls[0];
        usb_tx_en = tx;
        repeat (n) tick();
    endtask

    initial begin
        int onset;
        int r;
        logic [1:0] ls;

        reset_n   = 1'b0;
        usb_p_rx  = 1'b1;
        usb_n_rx  = 1'b0;
        usb_tx_en = 1'b0;
        model_reset();
        #12;
        check("reset.boot",  16'(bootloader_reset), 16'(1));
        check("reset.pulse", 16'(bus_reset_pulse),  16'(0));
        check("reset.line",  16'(line_state),       16'(J));
        check("reset.done",  16'(por_done),         16'(0));

        // Power-on: reset held for exactly POR cycles after release
        @(negedge clk_48mhz);
        reset_n = 1'b1;
        #1;
        check("por.boot_at_release", 16'(bootloader_reset), 16'(1));
        boot_hi = 0;
        pulses  = 0;
        drive(J, 1'b0, POR + 6);
        check("por.boot_high_edges", 16'(boot_hi), 16'(POR - 1));
        check("por.pulses", 16'(pulses), 16'(0));

        // Short SE0 must not qualify
        pulses = 0;
        drive(SE0, 1'b0, SE0N - 1);
        drive(J, 1'b0, 10);
        check("short.pulses", 16'(pulses), 16'(0));

        // Valid bus reset: strobe SYNC+SE0N cycles after onset
        pulses = 0;
        onset  = cyc;
        drive(SE0, 1'b0, 20);
        drive(J, 1'b0, 12);
        check("valid.pulses", 16'(pulses), 16'(1));
        check("valid.latency", 16'(pulse_cyc - onset), 16'(SYNC + SE0N));

        // Transmit masking and a K glitch breaking the count
        pulses = 0;
        drive(SE0, 1'b1, 50);
        drive(J, 1'b0, 4);
        drive(SE0, 1'b0, 4);
        drive(K, 1'b0, 1);
        drive(SE0, 1'b0, 4);
        drive(J, 1'b0, 6);
        drive(SE0, 1'b0, 5);
        drive(SE1, 1'b0, 1);
        drive(SE0, 1'b0, 5);
        drive(J, 1'b0, 6);
        check("mask.pulses", 16'(pulses), 16'(0));

        // Re-entry during HOLD: single strobe, reset held throughout
        pulses  = 0;
        drive(SE0, 1'b0, 20);
        drive(J, 1'b0, 3);
        drive(SE0, 1'b0, 10);
        drive(J, 1'b0, 12);
        check("reentry.pulses", 16'(pulses), 16'(1));

        // Async reset while in bus reset
        drive(SE0, 1'b0, 15);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("async.boot", 16'(bootloader_reset), 16'(1));
        check("async.done", 16'(por_done),         16'(0));
        check("async.line", 16'(line_state),       16'(J));
        check("async.pulse", 16'(bus_reset_pulse), 16'(0));
        usb_p_rx = 1'b1;
        usb_n_rx = 1'b0;
        repeat (2) @(negedge clk_48mhz);
        reset_n = 1'b1;
        boot_hi = 0;
        drive(J, 1'b0, POR + 4);
        check("async.por_repeat", 16'(boot_hi), 16'(POR - 1));

        // Random line activity against the reference
        for (int s = 0; s < 60; s++) begin
            r  = $urandom_range(0, 9);
            ls = (r < 5) ? SE0 : 2'($urandom_range(0, 3));
            drive(ls, ($urandom_range(0, 7) == 0), $urandom_range(1, 25));
        end
        drive(J, 1'b0, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_bus_reset_gen.md
Name: usb_bus_reset_gen

Overview:
- Generates the core reset for the bootloader from two sources:
  - power-on, after the async reset_n is released;
  - USB bus reset, i.e. SE0 held on D+/D- by the host for at least 2.5 us.
- Sits between the board-level USB tristate receive path and the tinyfpga_bootloader reset input.
- Runs on the 48 MHz clock so that SE0 timing is resolved finely.
- Also reports the decoded line state to the core.

Parameters:
- POR_CYCLES, 4800: cycles the power-on reset is held after reset_n rises (100 us at 48 MHz).
- SE0_CYCLES, 120: consecutive synchronised SE0 cycles that qualify as a bus reset (2.5 us at 48 MHz).
- HOLD_CYCLES, 48: cycles bootloader_reset stays asserted after SE0 ends; must be >= 4 clk_12mhz periods.
- SYNC_STAGES, 2: synchroniser depth on usb_p_rx and usb_n_rx (minimum 2).

Ports:
- clk_48mhz  input  1  48 MHz clock; the only clock.
- reset_n  input  1  asynchronous, active-low reset.
- usb_p_rx  input  1  D+ receive value (already forced to 1 by the top while transmitting).
- usb_n_rx  input  1  D- receive value (already forced to 0 by the top while transmitting).
- usb_tx_en  input  1  high while the core drives the bus.
- bootloader_reset  output  1  active-high reset to the bootloader core.
- bus_reset_pulse  output  1  one-cycle strobe when a bus reset is qualified.
- line_state  output  2  synchronised {dp,dn}: 10=J, 01=K, 00=SE0, 11=SE1.
- por_done  output  1  high once the power-on phase has completed; sticky until reset_n.

Behaviour:
- Reset values while reset_n is low (applied asynchronously):
  - synchroniser flops = J (dp=1, dn=0), so no false SE0 is seen out of reset;
  - line_state = 2'b10;
  - bootloader_reset = 1, bus_reset_pulse = 0, por_done = 0;
  - state = POR, counter = 0.
- Synchroniser: SYNC_STAGES flops per line. line_state is the last stage, so pin-to-line_state latency is SYNC_STAGES cycles.
- se0 condition: line_state == 00 and usb_tx_en == 0. usb_tx_en is used unsynchronised (same clock domain).
- Counter: a single shared counter, width $clog2 of max(POR_CYCLES, SE0_CYCLES, HOLD_CYCLES)+1. It saturates and never wraps.
- State machine:
  - POR: counter increments each cycle. On the cycle it reaches POR_CYCLES-1, go to IDLE. On that edge por_done goes 1 and bootloader_reset goes 0, so bootloader_reset is high for exactly POR_CYCLES cycles after reset_n release. SE0 is ignored in POR.
  - IDLE: bootloader_reset = 0. If se0, go to SE0_CNT with counter = 1.
  - SE0_CNT: if not se0 (J, K, SE1 or tx_en), return to IDLE and clear the counter. If se0 and counter == SE0_CYCLES-1, go to BUS_RESET. On that edge bus_reset_pulse = 1 for one cycle and bootloader_reset = 1. Otherwise increment the counter.
  - BUS_RESET: bootloader_reset = 1. When se0 drops, go to HOLD with counter = 0.
  - HOLD: bootloader_reset = 1; counter increments.
    - If se0 returns, go back to BUS_RESET with no new pulse.
    - At counter == HOLD_CYCLES-1, go to IDLE and deassert bootloader_reset on that edge.
- Detection latency: bus_reset_pulse rises SYNC_STAGES + SE0_CYCLES cycles after SE0 first appears at the pins.
- bootloader_reset is a registered output and is glitch-free.
- If reset_n is asserted mid-operation (any state): all outputs take their reset values immediately, and the POR sequence restarts on release.
- SE1 is treated as non-SE0 and breaks an SE0 count.

Decomposition:
- Shared package usb_reset_pkg contains:
  - line-state encodings LS_J=2'b10, LS_K=2'b01, LS_SE0=2'b00, LS_SE1=2'b11;
  - FSM state encodings ST_POR, ST_IDLE, ST_SE0_CNT, ST_BUS_RESET, ST_HOLD (3 bits).
- One sub-module, usb_line_sync: a parameterised SYNC_STAGES synchroniser on the 2-bit bus with a J reset value. It is instantiated once.
- The FSM and counter stay in the parent module.

Test Plan:
All scenarios use POR_CYCLES=16, SE0_CYCLES=8, HOLD_CYCLES=4, SYNC_STAGES=2.
- POR: release reset_n with the line at J -> bootloader_reset high for exactly 16 cycles; por_done rises on the same edge that bootloader_reset falls; bus_reset_pulse stays 0.
- Short SE0: after POR, drive SE0 for 7 cycles then J -> no bus_reset_pulse; bootloader_reset stays 0.
- Valid bus reset: drive SE0 for 20 cycles then J ->
  - bus_reset_pulse high for 1 cycle, 10 cycles after SE0 onset;
  - bootloader_reset high from that edge until 4 cycles after line_state returns to J.
- Transmit masking: usb_tx_en=1 with pins at SE0 for 50 cycles -> no pulse; bootloader_reset stays 0. Glitch case: a single K cycle inside an 8-cycle SE0 restarts the count.
- Re-entry: SE0 again during HOLD (cycle 2 of 4) -> returns to BUS_RESET; no second pulse; after the final SE0 ends, the full 4-cycle hold elapses before deassert.
- Async reset mid-operation: assert reset_n low during BUS_RESET -> same-cycle (async) bootloader_reset=1, por_done=0, line_state=10; after release, the full 16-cycle POR is repeated.
